instr_buffer: RTL and testbench
===============================

INSTR_BUFFER -- requirements
Module: instr_buffer

Interface
REQ-001 SHALL have parameter FETCH_WIDTH, default 2, instructions pushed per cycle from IF.
REQ-002 SHALL have parameter DECODE_WIDTH, default 2, instructions presented per cycle to ID/dispatch.
REQ-003 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2*FETCH_WIDTH.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous pipeline flush from ctrl.
REQ-007 frontend_valid_i  input  [FETCH_WIDTH]  per-lane push valid.
REQ-008 frontend_pc_i  input  [FETCH_WIDTH][32]  per-lane PC.
REQ-009 frontend_instr_i  input  [FETCH_WIDTH][32]  per-lane instruction word.
REQ-010 frontend_excp_i  input  [FETCH_WIDTH]  per-lane fetch exception flag.
REQ-011 frontend_stallreq_o  output  1  buffer cannot accept a full fetch group this cycle.
REQ-012 backend_accept_i  input  [DECODE_WIDTH]  per-slot consume mask from dispatch.
REQ-013 backend_valid_o  output  [DECODE_WIDTH]  per-slot output valid.
REQ-014 backend_pc_o, backend_instr_o, backend_excp_o  output  [DECODE_WIDTH][32]/[32]/[1]  head entries, slot 0 = oldest.
REQ-015 count_o  output  $clog2(DEPTH)+1  occupied entries (registered).

Function
REQ-016 Storage SHALL be a circular array with registered head pointer, tail pointer, count; pointers wrap modulo DEPTH.
REQ-017 frontend_stallreq_o SHALL equal (DEPTH - count) < FETCH_WIDTH, derived from registered count only (no combinational path from backend_accept_i).
REQ-018 Push SHALL occur only when frontend_stallreq_o=0 and flush=0; lanes with valid=1 written in lane order to consecutive entries from tail (compaction: mask 2'b10 writes lane 1 at tail).
REQ-019 Pushed lanes while frontend_stallreq_o=1 SHALL be dropped; IF is responsible for holding them.
REQ-020 Outputs SHALL be show-ahead: slot k presents entry head+k combinationally; backend_valid_o[k]=1 iff k < count and flush=0.
REQ-021 Pop count SHALL be the length of the contiguous leading run of ones in (backend_accept_i & backend_valid_o); accept 2'b10 pops nothing.
REQ-022 Head SHALL advance by pop count; tail by number of pushed lanes; count' = count + pushed - popped, same cycle, never exceeding DEPTH.
REQ-023 Simultaneous push and pop on full/near-full buffer SHALL use pre-pop count for stallreq (conservative); no entry overwritten before popped.
REQ-024 Push into empty buffer SHALL be visible on backend outputs the next cycle (1-cycle latency); no same-cycle bypass.
REQ-025 flush=1 SHALL set head, tail, count to 0 at next edge, discard same-cycle push and pop, and force backend_valid_o=0 during the flush cycle.
REQ-026 Payload array contents SHALL not require reset; only pointers/count reset.
REQ-027 Wrap-around: a fetch group spanning index DEPTH-1 to 0 SHALL be stored and presented in order.

Reset
REQ-028 While rst_n=0: head=0, tail=0, count_o=0, backend_valid_o=0, frontend_stallreq_o=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries immediately; first push after release appears at slot 0 one cycle later.

Verification
REQ-030 Reset then push {pc 0x1c000000, 0x1c000004} valid 2'b11, accept 0 -> next cycle valid_o=2'b11, pc_o={0x1c000004,0x1c000000}, count_o=2.
REQ-031 Push 8 groups of 2 with accept 0 (DEPTH 16) -> count_o=16, stallreq=1; 9th group dropped; count_o stays 16.
REQ-032 Full buffer, accept 2'b01 each cycle -> count 16->15 (stallreq=1 since 1<2), 15->14 stallreq=0; PC order preserved.
REQ-033 Push mask 2'b10 with pc_i[1]=0x1c000040 into empty buffer -> next cycle slot 0 pc=0x1c000040, valid_o=2'b01.
REQ-034 Count 5, push 2'b11 + accept 2'b11 + flush=1 same cycle -> valid_o=0 that cycle, count_o=0 next cycle, no stale entry later.
REQ-035 Random push/accept for 10k cycles with head starting at DEPTH-1 -> scoreboard: popped PC sequence equals pushed sequence, count_o never > DEPTH.

Source files
------------

// File: rtl/instr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : instr_buffer
// Brief    : Circular fetch-to-decode instruction queue with show-ahead output.
// Revision : 1.0
// ============================================================================
module instr_buffer #(
    parameter int FETCH_WIDTH  = 2,
    parameter int DECODE_WIDTH = 2,
    parameter int DEPTH        = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               flush,
    input  logic [FETCH_WIDTH-1:0]             frontend_valid_i,
    input  logic [FETCH_WIDTH-1:0][31:0]       frontend_pc_i,
    input  logic [FETCH_WIDTH-1:0][31:0]       frontend_instr_i,
    input  logic [FETCH_WIDTH-1:0]             frontend_excp_i,
    output logic                               frontend_stallreq_o,
    input  logic [DECODE_WIDTH-1:0]            backend_accept_i,
    output logic [DECODE_WIDTH-1:0]            backend_valid_o,
    output logic [DECODE_WIDTH-1:0][31:0]      backend_pc_o,
    output logic [DECODE_WIDTH-1:0][31:0]      backend_instr_o,
    output logic [DECODE_WIDTH-1:0]            backend_excp_o,
    output logic [$clog2(DEPTH):0]             count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        excp;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [CW-1:0]   w_free;
    logic            w_stall;
    logic            w_push_en;
    logic [CW-1:0]   w_push_cnt;
    logic [CW-1:0]   w_pushed;
    logic [AW-1:0]   w_lane_off [FETCH_WIDTH];
    logic [CW-1:0]   w_pop_cnt;
    logic            w_run;
    logic [AW-1:0]   w_rd_idx [DECODE_WIDTH];

    // Stall looks only at the registered count, so a same-cycle pop never frees space early.
    assign w_free              = CW'(DEPTH) - count_q;
    assign w_stall             = (w_free < CW'(FETCH_WIDTH));
    assign w_push_en           = !w_stall && !flush;
    assign frontend_stallreq_o = w_stall;
    assign count_o             = count_q;

    // Valid lanes are compacted: each lands at tail plus the number of valid lanes below it.
    always_comb begin
        w_push_cnt = '0;
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            w_lane_off[l] = w_push_cnt[AW-1:0];
            w_push_cnt    = w_push_cnt + {{(CW-1){1'b0}}, frontend_valid_i[l]};
        end
        w_pushed = w_push_en ? w_push_cnt : '0;
    end

    always_comb begin
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            w_rd_idx[k]        = head_q + AW'(k);
            backend_pc_o[k]    = mem_q[w_rd_idx[k]].pc;
            backend_instr_o[k] = mem_q[w_rd_idx[k]].instr;
            backend_excp_o[k]  = mem_q[w_rd_idx[k]].excp;
            backend_valid_o[k] = (CW'(k) < count_q) && !flush;
        end
    end

    // Only an unbroken run of accepted slots from slot 0 is consumed.
    always_comb begin
        w_pop_cnt = '0;
        w_run     = 1'b1;
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            w_run     = w_run & backend_accept_i[k] & backend_valid_o[k];
            w_pop_cnt = w_pop_cnt + {{(CW-1){1'b0}}, w_run};
        end
    end

    always_comb begin
        head_d  = head_q + w_pop_cnt[AW-1:0];
        tail_d  = tail_q + w_pushed[AW-1:0];
        count_d = count_q + w_pushed - w_pop_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset; occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        for (int l = 0; l < FETCH_WIDTH; l++) begin
            if (w_push_en && frontend_valid_i[l]) begin
                mem_q[tail_q + w_lane_off[l]] <= '{pc:    frontend_pc_i[l],
                                                   instr: frontend_instr_i[l],
                                                   excp:  frontend_excp_i[l]};
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_buffer
// Brief    : Directed table vectors plus scoreboarded sequences for instr_buffer.
// Revision : 1.0
// ============================================================================
module tb_instr_buffer;

    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic [1:0]       fv;
    logic [1:0][31:0] fpc;
    logic [1:0][31:0] finstr;
    logic [1:0]       fexcp;
    logic             stall;
    logic [1:0]       acc;
    logic [1:0]       bv;
    logic [1:0][31:0] bpc;
    logic [1:0][31:0] binstr;
    logic [1:0]       bexcp;
    logic [4:0]       cnt;

    int checks = 0;
    int errors = 0;

    instr_buffer #(.FETCH_WIDTH(2), .DECODE_WIDTH(2), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .flush               (flush),
        .frontend_valid_i    (fv),
        .frontend_pc_i       (fpc),
        .frontend_instr_i    (finstr),
        .frontend_excp_i     (fexcp),
        .frontend_stallreq_o (stall),
        .backend_accept_i    (acc),
        .backend_valid_o     (bv),
        .backend_pc_o        (bpc),
        .backend_instr_o     (binstr),
        .backend_excp_o      (bexcp),
        .count_o             (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic [1:0]  v;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  ac;
        logic [1:0]  ev;
        logic [31:0] epc0;
        logic [31:0] epc1;
        logic [4:0]  ecnt;
        logic        estall;
    } vec_t;

    vec_t        tbl [18];
    logic [31:0] q [$];
    logic [31:0] pc_base;

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return pc ^ 32'hdeadbeef;
    endfunction

    function automatic vec_t mk(input logic fl, input logic [1:0] v, input logic [31:0] pc0,
                                input logic [31:0] pc1, input logic [1:0] ac, input logic [1:0] ev,
                                input logic [31:0] epc0, input logic [31:0] epc1,
                                input logic [4:0] ecnt, input logic estall);
        vec_t r;
        r.fl = fl; r.v = v; r.pc0 = pc0; r.pc1 = pc1; r.ac = ac;
        r.ev = ev; r.epc0 = epc0; r.epc1 = epc1; r.ecnt = ecnt; r.estall = estall;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fl, input logic [1:0] v, input logic [31:0] pc0,
                         input logic [31:0] pc1, input logic [1:0] ac);
        flush     = fl;
        fv        = v;
        fpc[0]    = pc0;
        fpc[1]    = pc1;
        finstr[0] = instr_of(pc0);
        finstr[1] = instr_of(pc1);
        fexcp[0]  = pc0[3];
        fexcp[1]  = pc1[3];
        acc       = ac;
    endtask

    // One cycle against the queue model; inputs driven just after posedge, checked at negedge.
    task automatic sb_cycle(input logic [1:0] v, input logic [1:0] ac);
        int  n;
        int  npop;
        logic run;
        logic mstall;
        drive(1'b0, v, pc_base, pc_base + 32'd4, ac);
        @(negedge clk);
        n      = q.size();
        mstall = ((DEPTH - n) < 2);
        chk("sb_count", 32'(cnt), 32'(n));
        chk("sb_stall", 32'(stall), 32'(mstall));
        chk("sb_valid", 32'(bv), {30'd0, (n > 1), (n > 0)});
        run  = 1'b1;
        npop = 0;
        for (int k = 0; k < 2; k++) begin
            if (k < n) begin
                chk("sb_pc", bpc[k], q[k]);
                chk("sb_instr", binstr[k], instr_of(q[k]));
                chk("sb_excp", 32'(bexcp[k]), 32'(q[k][3]));
            end
            run = run && ac[k] && (k < n);
            if (run) npop++;
        end
        for (int k = 0; k < npop; k++) void'(q.pop_front());
        if (!mstall) begin
            for (int l = 0; l < 2; l++)
                if (v[l]) q.push_back(pc_base + 32'(4 * l));
        end
        pc_base = pc_base + 32'd8;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        pc_base = 32'h1c001000;
        drive(1'b0, 2'b00, 32'd0, 32'd0, 2'b00);

        tbl[0]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);
        tbl[1]  = mk(0, 2'b11, 32'h1c000000, 32'h1c000004, 2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);
        tbl[2]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b11, 32'h1c000000, 32'h1c000004, 5'd2, 0);
        tbl[3]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b10, 2'b11, 32'h1c000000, 32'h1c000004, 5'd2, 0);
        tbl[4]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b01, 2'b11, 32'h1c000000, 32'h1c000004, 5'd2, 0);
        tbl[5]  = mk(0, 2'b10, 32'h0,        32'h1c000040, 2'b00, 2'b01, 32'h1c000004, 32'h0,        5'd1, 0);
        tbl[6]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b11, 2'b11, 32'h1c000004, 32'h1c000040, 5'd2, 0);
        tbl[7]  = mk(0, 2'b10, 32'h0,        32'h1c000080, 2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);
        tbl[8]  = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b01, 32'h1c000080, 32'h0,        5'd1, 0);
        tbl[9]  = mk(0, 2'b11, 32'h1c0000a0, 32'h1c0000a4, 2'b00, 2'b01, 32'h1c000080, 32'h0,        5'd1, 0);
        tbl[10] = mk(0, 2'b11, 32'h1c0000a8, 32'h1c0000ac, 2'b00, 2'b11, 32'h1c000080, 32'h1c0000a0, 5'd3, 0);
        tbl[11] = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b11, 32'h1c000080, 32'h1c0000a0, 5'd5, 0);
        tbl[12] = mk(1, 2'b11, 32'h1c0000b0, 32'h1c0000b4, 2'b11, 2'b00, 32'h0,        32'h0,        5'd5, 0);
        tbl[13] = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);
        tbl[14] = mk(0, 2'b11, 32'h1c0000c0, 32'h1c0000c4, 2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);
        tbl[15] = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b11, 32'h1c0000c0, 32'h1c0000c4, 5'd2, 0);
        tbl[16] = mk(0, 2'b00, 32'h0,        32'h0,        2'b11, 2'b11, 32'h1c0000c0, 32'h1c0000c4, 5'd2, 0);
        tbl[17] = mk(0, 2'b00, 32'h0,        32'h0,        2'b00, 2'b00, 32'h0,        32'h0,        5'd0, 0);

        // Reset state
        @(negedge clk);
        chk("rst_count", 32'(cnt), 32'd0);
        chk("rst_valid", 32'(bv), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].fl, tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].ac);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), 32'(bv), 32'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), 32'(cnt), 32'(tbl[i].ecnt));
            chk($sformatf("tbl%0d_stall", i), 32'(stall), 32'(tbl[i].estall));
            if (tbl[i].ev[0]) begin
                chk($sformatf("tbl%0d_pc0", i), bpc[0], tbl[i].epc0);
                chk($sformatf("tbl%0d_instr0", i), binstr[0], instr_of(tbl[i].epc0));
                chk($sformatf("tbl%0d_excp0", i), 32'(bexcp[0]), 32'(tbl[i].epc0[3]));
            end
            if (tbl[i].ev[1]) chk($sformatf("tbl%0d_pc1", i), bpc[1], tbl[i].epc1);
            @(posedge clk);
            #1;
        end

        // Fill to DEPTH (head and tail sit at 2, so the fill wraps), overflow group dropped
        q.delete();
        for (int g = 0; g < 8; g++) sb_cycle(2'b11, 2'b00);
        sb_cycle(2'b11, 2'b00);
        chk("full_count", 32'(cnt), 32'd16);
        chk("full_stall", 32'(stall), 32'd1);
        sb_cycle(2'b00, 2'b01);
        sb_cycle(2'b00, 2'b01);
        chk("drain1_count", 32'(cnt), 32'd14);
        chk("drain1_stall", 32'(stall), 32'd0);
        for (int g = 0; g < 8; g++) sb_cycle(2'b00, 2'b11);
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Asynchronous reset mid-operation
        sb_cycle(2'b11, 2'b00);
        sb_cycle(2'b11, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("midrst_count", 32'(cnt), 32'd0);
        chk("midrst_valid", 32'(bv), 32'd0);
        chk("midrst_stall", 32'(stall), 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_cycle(2'b11, 2'b00);
        chk("postrst_pc0", bpc[0], pc_base - 32'd8);
        sb_cycle(2'b00, 2'b11);

        // Walk head to DEPTH-1, then random traffic across the wrap
        for (int i = 0; i < 13; i++) sb_cycle(2'b01, 2'b01);
        sb_cycle(2'b00, 2'b01);
        chk("head_setup_empty", 32'(cnt), 32'd0);
        for (int i = 0; i < 10000; i++)
            sb_cycle(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
